// File: rtl/muldiv_seq.sv
// Sequential RV32M-style multiply/divide unit: one bit per cycle in CALC,
// with sign correction and special-case results applied in FIXUP.
module muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [N-1:0]    r_opd;
  logic [2*N-1:0]  r_prod;
  logic [N-1:0]    r_result;

  logic            w_sa, w_sb;
  logic [N-1:0]    w_mag_a, w_mag_b;
  logic            w_div0, w_ovf, w_special;
  logic [N-1:0]    w_spec_val;
  logic [N:0]      w_add;
  logic [N:0]      w_trial;
  logic [2*N-1:0]  w_iter;
  logic [2*N-1:0]  w_prod_s;
  logic [N-1:0]    w_fix;

  function automatic logic [N-1:0] f_cneg(input logic [N-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*N-1:0] f_cneg2(input logic [2*N-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Operand decode at the accepting edge: signs, magnitudes, special cases
  always_comb begin
    w_sa       = ((funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                  (funct3 == F_DIV)  || (funct3 == F_REM)) && a[N-1];
    w_sb       = ((funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM)) && b[N-1];
    w_mag_a    = f_cneg(a, w_sa);
    w_mag_b    = f_cneg(b, w_sb);
    w_div0     = funct3[2] && (b == '0);
    w_ovf      = funct3[2] && !funct3[0] && (a == MOST_NEG) && (b == '1);
    w_special  = w_div0 || w_ovf;
    if (w_div0) w_spec_val = funct3[1] ? a : '1;
    else        w_spec_val = funct3[1] ? '0 : a;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // For divide the upper half is the partial remainder, the lower half the quotient.
  always_comb begin
    w_add   = {1'b0, r_prod[2*N-1:N]} + {1'b0, r_opd};
    w_trial = {r_prod[2*N-1:N], r_prod[N-1]} - {1'b0, r_opd};
    if (r_f3[2]) begin
      if (w_trial[N]) w_iter = {r_prod[2*N-2:0], 1'b0};
      else            w_iter = {w_trial[N-1:0], r_prod[N-2:0], 1'b1};
    end else begin
      if (r_prod[0])  w_iter = {w_add, r_prod[N-1:1]};
      else            w_iter = {1'b0, r_prod[2*N-1:1]};
    end
  end

  always_comb begin
    w_prod_s = f_cneg2(r_prod, r_neg_q);
    case (r_f3)
      F_MUL:                      w_fix = r_prod[N-1:0];
      F_MULH, F_MULHSU, F_MULHU:  w_fix = w_prod_s[2*N-1:N];
      F_DIV, F_DIVU:              w_fix = f_cneg(r_prod[N-1:0], r_neg_q);
      default:                    w_fix = f_cneg(r_prod[2*N-1:N], r_neg_r);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_special ? S_FIXUP : S_CALC;
      S_CALC:  if (r_cnt == LAST) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Special cases preload both halves so either result selection yields the value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opd    <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3  <= funct3;
            r_cnt <= '0;
            if (w_special) begin
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_opd   <= '0;
              r_prod  <= {w_spec_val, w_spec_val};
            end else begin
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
              if (funct3[2]) begin
                r_opd  <= w_mag_b;
                r_prod <= {{N{1'b0}}, w_mag_a};
              end else begin
                r_opd  <= w_mag_a;
                r_prod <= {{N{1'b0}}, w_mag_b};
              end
            end
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CW'(1);
          r_prod <= w_iter;
        end
        S_FIXUP: r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign Result = r_result;

endmodule
